// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_arb_pkg
// Purpose : Shared types and default sizes for the N-channel SDRAM bridge
//           arbiter.
// Contents: arb_state_t - arbiter FSM state encoding (IDLE/BUSY/RESP)
//           DEF_NCH/DEF_AW/DEF_DW - default channel count, word-address
//           width and data width.
// Revision: 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  localparam int DEF_NCH = 3;
  localparam int DEF_AW  = 25;
  localparam int DEF_DW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational winner selection for the SDRAM arbiter.
//           Round-robin: the search starts one past i_ptr and wraps.
//           With SDRAM_ARB_FIXED_PRI_EN defined, the lowest requesting index
//           wins and i_ptr is ignored.
// Ports   : i_req       - per-channel request vector
//           i_ptr       - index of the last granted channel
//           o_grant_oh  - one-hot winner (all zero when no request)
//           o_grant_idx - binary winner index
//           o_any       - at least one channel is requesting
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int IW  = $clog2(DEF_NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant_oh,
  output logic [IW-1:0]  o_grant_idx,
  output logic           o_any
);

  // Each requester gets a priority distance; the smallest distance wins.
  int w_dist;
  int w_best;
  int w_sel;

`ifdef SDRAM_ARB_FIXED_PRI_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`endif

  always_comb begin
    w_dist      = 0;
    w_best      = NCH;
    w_sel       = 0;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (i_req[c]) begin
`ifdef SDRAM_ARB_FIXED_PRI_EN
        w_dist = c;
`else
        // Distance from the slot just after the pointer, modulo NCH.
        w_dist = (c + NCH - 1 - int'(i_ptr)) % NCH;
`endif
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_sel  = c;
        end
      end
    end
    if (w_best < NCH) begin
      o_any       = 1'b1;
      o_grant_idx = IW'(w_sel);
    end
    for (int c = 0; c < NCH; c++) begin
      o_grant_oh[c] = o_any && (w_sel == c);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter_nch.sv
`default_nettype none
// ============================================================================
// Module  : sdram_arbiter_nch
// Purpose : Shares one SDRAM bridge port among NCH masters. One transaction
//           at a time; winner chosen by round-robin (or fixed priority when
//           SDRAM_ARB_FIXED_PRI_EN is defined). All bridge outputs, the
//           acknowledge pulse and the read data are registered.
// Ports   : clk, reset (async, active-high)
//           req_read/req_write/req_addr/req_be/req_wrdata - packed client
//             requests, channel i at slice i
//           req_ack/req_rddata - per-channel one-cycle ack, shared read data
//           br_* - bridge side (address, byte enable, strobes, write data,
//             acknowledge, read data)
//           grant_id - channel currently or last granted
//           busy - high from grant until the response cycle ends
// Config  : SDRAM_ARB_FIXED_PRI_EN - fixed lowest-index-wins priority
// Revision: 1.0 - initial release
// ============================================================================
module sdram_arbiter_nch
  import sdram_arb_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  parameter  int AW  = DEF_AW,
  parameter  int DW  = DEF_DW,
  localparam int BEW = DW / 8,
  localparam int IW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_read,
  input  logic [NCH-1:0]    req_write,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*BEW-1:0] req_be,
  input  logic [NCH*DW-1:0] req_wrdata,
  output logic [NCH-1:0]    req_ack,
  output logic [DW-1:0]     req_rddata,
  output logic [AW-1:0]     br_address,
  output logic [BEW-1:0]    br_byte_enable,
  output logic              br_read,
  output logic              br_write,
  output logic [DW-1:0]     br_write_data,
  input  logic              br_acknowledge,
  input  logic [DW-1:0]     br_read_data,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  arb_state_t       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_grant_id;
  logic [NCH-1:0]   r_grant_oh;
  logic [NCH-1:0]   r_req_ack;
  logic [DW-1:0]    r_req_rddata;
  logic [AW-1:0]    r_br_address;
  logic [BEW-1:0]   r_br_byte_enable;
  logic             r_br_read;
  logic             r_br_write;
  logic [DW-1:0]    r_br_write_data;
  logic             r_busy;

  logic [NCH-1:0]   w_req;
  logic [NCH-1:0]   w_grant_oh;
  logic [IW-1:0]    w_grant_idx;
  logic             w_any;
  logic [AW-1:0]    w_sel_addr;
  logic [BEW-1:0]   w_sel_be;
  logic [DW-1:0]    w_sel_wrdata;
  logic             w_sel_write;

  assign w_req = req_read | req_write;

  rr_picker #(
    .NCH (NCH),
    .IW  (IW)
  ) u_picker (
    .i_req       (w_req),
    .i_ptr       (r_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Steer the winning channel's fields toward the bridge registers.
  always_comb begin
    w_sel_addr   = '0;
    w_sel_be     = '0;
    w_sel_wrdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_grant_oh[c]) begin
        w_sel_addr   = req_addr[c*AW +: AW];
        w_sel_be     = req_be[c*BEW +: BEW];
        w_sel_wrdata = req_wrdata[c*DW +: DW];
      end
    end
    // Write takes precedence when a channel raises both strobes.
    w_sel_write = |(w_grant_oh & req_write);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_ptr            <= IW'(NCH - 1);
      r_grant_id       <= '0;
      r_grant_oh       <= '0;
      r_req_ack        <= '0;
      r_req_rddata     <= '0;
      r_br_address     <= '0;
      r_br_byte_enable <= '0;
      r_br_read        <= 1'b0;
      r_br_write       <= 1'b0;
      r_br_write_data  <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_req_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_br_address     <= w_sel_addr;
            r_br_byte_enable <= w_sel_be;
            r_br_write_data  <= w_sel_wrdata;
            r_br_write       <= w_sel_write;
            r_br_read        <= ~w_sel_write;
            r_grant_id       <= w_grant_idx;
            r_grant_oh       <= w_grant_oh;
            r_ptr            <= w_grant_idx;
            r_busy           <= 1'b1;
            r_state          <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (br_acknowledge) begin
            r_br_read  <= 1'b0;
            r_br_write <= 1'b0;
            if (r_br_read) begin
              r_req_rddata <= br_read_data;
            end
            r_req_ack <= r_grant_oh;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_br_read  <= 1'b0;
          r_br_write <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack        = r_req_ack;
  assign req_rddata     = r_req_rddata;
  assign br_address     = r_br_address;
  assign br_byte_enable = r_br_byte_enable;
  assign br_read        = r_br_read;
  assign br_write       = r_br_write;
  assign br_write_data  = r_br_write_data;
  assign grant_id       = r_grant_id;
  assign busy           = r_busy;

endmodule
`default_nettype wire
